// File: rtl/fpadd_pkg.sv
// fpadd_pkg
// Shared types and constants for the sequential binary32 adder.
// Contents:
//   fpadd_state_t : controller state encoding
//   fp32_t        : packed binary32 view {sign, exp, frac}
//   unpack_mant   : 24-bit mantissa with hidden bit; denormals flush to zero
// The optional FPADD_SPECIALS_EN build macro is consumed by fpadd_seq.
package fpadd_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MANT_W   = 24;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } fpadd_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  function automatic logic [MANT_W-1:0] unpack_mant(input fp32_t f);
    return (f.exp != 8'd0) ? {1'b1, f.frac} : '0;
  endfunction

endpackage

// File: rtl/fpadd_seq_align.sv
// mant_align
// Combinational alignment shifter shared by the adder. Selects the smaller
// mantissa and shifts it right, truncating shifted-out bits.
// Ports:
//   swap    : 1 = operand B is the larger, so A's mantissa is shifted
//   mant_a  : 24-bit mantissa of A
//   mant_b  : 24-bit mantissa of B
//   shift   : exponent difference
//   aligned : shifted smaller mantissa, zero once shift reaches 24
module mant_align
  import fpadd_pkg::*;
(
  input  logic              swap,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic [EXP_W-1:0]  shift,
  output logic [MANT_W-1:0] aligned
);

  logic [MANT_W-1:0] mant_small;

  always_comb begin
    mant_small = swap ? mant_a : mant_b;
    aligned    = (shift >= 8'd24) ? '0 : (mant_small >> shift);
  end

endmodule

// File: rtl/fpadd_seq.sv
// fpadd_seq
// Multi-cycle binary32 adder: IDLE -> ALIGN -> ADD -> NORM (iterative) -> DONE.
// Truncating alignment, denormals flushed to zero, saturation to inf.
// Build option: define FPADD_SPECIALS_EN to short-circuit inf/NaN operands
// from ALIGN straight to DONE; otherwise exp==255 is treated as a normal.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b)
//   out_valid, out_ready: result handshake (result)
//   busy                : high outside IDLE
//
// state | meaning
// IDLE  | waiting for an operand pair
// ALIGN | exponent compare, swap, align smaller mantissa
// ADD   | magnitude add or subtract
// NORM  | one normalization step per cycle
// DONE  | result presented until accepted
module fpadd_seq
  import fpadd_pkg::*;
#(
  parameter int NORM_MAX = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int CNT_W = $clog2(NORM_MAX + 1);

  fpadd_state_t state, state_next;

  fp32_t             op_a, op_b;
  logic [MANT_W-1:0] mant_large, mant_aligned;
  logic [EXP_W-1:0]  res_exp;
  logic              res_sign;
  logic              op_sub;
  logic [MANT_W:0]   sum;
  logic [CNT_W-1:0]  norm_cnt;
  logic [31:0]       res_q;

  logic [MANT_W-1:0] mant_a, mant_b, aligned;
  logic              b_large;
  logic [EXP_W-1:0]  shift;
  logic              special;
  logic [31:0]       special_res;
  logic              underflow;
  logic              norm_exit;

  always_comb begin
    mant_a  = unpack_mant(op_a);
    mant_b  = unpack_mant(op_b);
    b_large = (op_b.exp > op_a.exp) ||
              ((op_b.exp == op_a.exp) && (mant_b > mant_a));
    shift   = b_large ? (op_b.exp - op_a.exp) : (op_a.exp - op_b.exp);
  end

  mant_align u_align (
    .swap    (b_large),
    .mant_a  (mant_a),
    .mant_b  (mant_b),
    .shift   (shift),
    .aligned (aligned)
  );

`ifdef FPADD_SPECIALS_EN
  logic a_inf, b_inf, a_nan, b_nan;
  always_comb begin
    a_inf   = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
    b_inf   = (op_b.exp == EXP_MAX) && (op_b.frac == '0);
    a_nan   = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
    b_nan   = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
    special = (op_a.exp == EXP_MAX) || (op_b.exp == EXP_MAX);
    if (a_nan || b_nan)
      special_res = QNAN;
    else if (a_inf && b_inf)
      special_res = (op_a.sign != op_b.sign) ? QNAN : op_a;
    else if (a_inf)
      special_res = op_a;
    else
      special_res = op_b;
  end
`else
  always_comb begin
    special     = 1'b0;
    special_res = POS_ZERO;
  end
`endif

  // The counter cap is a backstop; with NORM_MAX >= 24 the leading one is
  // always found first.
  always_comb begin
    underflow = (res_exp == 8'd1) || (norm_cnt == CNT_W'(NORM_MAX));
    norm_exit = sum[MANT_W] || (sum == '0) || sum[MANT_W-1] || underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ALIGN;
      ALIGN:   state_next = special ? DONE : ADD;
      ADD:     state_next = NORM;
      NORM:    if (norm_exit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a         <= '0;
      op_b         <= '0;
      mant_large   <= '0;
      mant_aligned <= '0;
      res_exp      <= '0;
      res_sign     <= 1'b0;
      op_sub       <= 1'b0;
      sum          <= '0;
      norm_cnt     <= '0;
      res_q        <= POS_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= b;
          end
        end
        ALIGN: begin
          mant_large   <= b_large ? mant_b : mant_a;
          mant_aligned <= aligned;
          res_exp      <= b_large ? op_b.exp : op_a.exp;
          res_sign     <= b_large ? op_b.sign : op_a.sign;
          op_sub       <= op_a.sign ^ op_b.sign;
          norm_cnt     <= '0;
          if (special) res_q <= special_res;
        end
        ADD: begin
          sum <= op_sub ? ({1'b0, mant_large} - {1'b0, mant_aligned})
                        : ({1'b0, mant_large} + {1'b0, mant_aligned});
        end
        NORM: begin
          if (sum[MANT_W]) begin
            sum     <= sum >> 1;
            res_exp <= res_exp + 8'd1;
            // 254 or 255 would carry into (or past) the inf exponent.
            if (res_exp >= 8'hFE) res_q <= {res_sign, EXP_MAX, 23'h0};
            else                  res_q <= {res_sign, res_exp + 8'd1, sum[23:1]};
          end else if (sum == '0) begin
            res_q <= POS_ZERO;
          end else if (sum[MANT_W-1]) begin
            if (res_exp == EXP_MAX) res_q <= {res_sign, EXP_MAX, 23'h0};
            else                    res_q <= {res_sign, res_exp, sum[22:0]};
          end else if (underflow) begin
            res_q <= POS_ZERO;
          end else begin
            sum      <= sum << 1;
            res_exp  <= res_exp - 8'd1;
            norm_cnt <= norm_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    busy      = (state != IDLE) && !reset;
    out_valid = (state == DONE) && !reset;
    result    = res_q;
  end

endmodule

// File: tb/tb_fpadd_seq.sv
module tb_fpadd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  fpadd_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: value-level description of the truncating flush-to-zero adder.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int ea, eb, ma, mb, el, es, ml, ms, sh, al, s, p, k, e;
    logic sa, sb, sl;
    logic [31:0] sv;
    sa = x[31]; sb = y[31];
    ea = int'(x[30:23]); eb = int'(y[30:23]);
    ma = (ea != 0) ? (int'(x[22:0]) + (1 << 23)) : 0;
    mb = (eb != 0) ? (int'(y[22:0]) + (1 << 23)) : 0;
`ifdef FPADD_SPECIALS_EN
    if (ea == 255 || eb == 255) begin
      lat = 2;
      if ((ea == 255 && x[22:0] != 0) || (eb == 255 && y[22:0] != 0)) r = 32'h7FC00000;
      else if (ea == 255 && eb == 255) r = (sa != sb) ? 32'h7FC00000 : x;
      else if (ea == 255) r = x;
      else r = y;
      return;
    end
`endif
    if (eb > ea || (eb == ea && mb > ma)) begin
      el = eb; es = ea; ml = mb; ms = ma; sl = sb;
    end else begin
      el = ea; es = eb; ml = ma; ms = mb; sl = sa;
    end
    sh = el - es;
    al = (sh >= 24) ? 0 : (ms >> sh);
    s  = (sa == sb) ? ml + al : ml - al;
    lat = 4;
    if (s == 0) begin
      r = 32'h0;
    end else if (s >= (1 << 24)) begin
      e = el + 1;
      sv = 32'(s >> 1);
      r = (e >= 255) ? {sl, 8'hFF, 23'h0} : {sl, 8'(e), sv[22:0]};
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (((s >> i) & 1) == 1) p = i;
      k = 23 - p;
      if (el - k >= 1) begin
        e = el - k;
        sv = 32'(s << k);
        r = (e == 255) ? {sl, 8'hFF, 23'h0} : {sl, 8'(e), sv[22:0]};
        lat = 4 + k;
      end else begin
        r = 32'h0;
        lat = 4 + el - 1;
      end
    end
  endfunction

  // Drives one handshake and returns the first out_valid cycle (0 = timeout).
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] got, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : 0;
    got = result;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL rst_result got %h exp 0", result); end
    reset = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    int          vl [6];
    logic [31:0] got;
    int lat;
    va = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000};
    vb = '{32'h3F800000, 32'hBFA00000, 32'h30800000, 32'h34000000, 32'h7F7FFFFF, 32'h00000000};
    vr = '{32'h40000000, 32'h3E800000, 32'h3F800000, 32'h3F800001, 32'h7F800000, 32'h3F800000};
    vl = '{4, 6, 4, 4, 4, 4};
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], got, lat);
      tests_run++;
      if (got !== vr[i]) begin tests_failed++; $display("FAIL dir%0d_result got %h exp %h", i, got, vr[i]); end
      tests_run++;
      if (lat != vl[i]) begin tests_failed++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, vl[i]); end
      accept();
    end
  endtask

  task automatic test_stall();
    logic [31:0] got, er;
    int lat, el;
    issue(32'h40490FDB, 32'hC0490FDB, got, lat);
    tests_run++; if (got !== 32'h0) begin tests_failed++; $display("FAIL stall_result got %h exp 0", got); end
    tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL stall_latency got %0d exp 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || result !== 32'h0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got v=%b r=%h ir=%b busy=%b exp v=1 r=0 ir=0 busy=1",
                 i, out_valid, result, in_ready, busy);
      end
    end
    accept();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release got v=%b ir=%b exp v=0 ir=1", out_valid, in_ready);
    end
    model(32'h3F800000, 32'hBF000000, er, el);
    issue(32'h3F800000, 32'hBF000000, got, lat);
    tests_run++; if (got !== er) begin tests_failed++; $display("FAIL b2b_result got %h exp %h", got, er); end
    tests_run++; if (lat != el) begin tests_failed++; $display("FAIL b2b_latency got %0d exp %0d", lat, el); end
    accept();
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    int lat;
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'hBFA00000;
    @(posedge clk); #1;          // cycle 1: ALIGN
    in_valid = 1'b0;
    @(posedge clk); #1;          // cycle 2: ADD
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_state got v=%b r=%h busy=%b ir=%b exp v=0 r=0 busy=0 ir=1",
               out_valid, result, busy, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_no_valid%0d got 1 exp 0", i); end
    end
    issue(32'h3F800000, 32'h3F800000, got, lat);
    tests_run++; if (got !== 32'h40000000) begin tests_failed++; $display("FAIL abort_next got %h exp 40000000", got); end
    tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL abort_next_latency got %0d exp 4", lat); end
    accept();
  endtask

  task automatic test_specials();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] got, er;
    int lat, el;
    va = '{32'h7F800000, 32'h7FC00001, 32'h7F800000, 32'hFF800000};
    vb = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'hFF800000};
    for (int i = 0; i < 4; i++) begin
      model(va[i], vb[i], er, el);
      issue(va[i], vb[i], got, lat);
      tests_run++; if (got !== er) begin tests_failed++; $display("FAIL spec%0d_result got %h exp %h", i, got, er); end
      tests_run++; if (lat != el) begin tests_failed++; $display("FAIL spec%0d_latency got %0d exp %0d", i, lat, el); end
      accept();
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, got, er;
    int lat, el;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y[30:23] = x[30:23] + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) y[22:0] = x[22:0] ^ 23'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) x[30:23] = 8'h00;
      model(x, y, er, el);
      issue(x, y, got, lat);
      tests_run++;
      if (got !== er || lat != el) begin
        tests_failed++;
        $display("FAIL rand%0d %h+%h got %h lat %0d exp %h lat %0d", i, x, y, got, lat, er, el);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_abort();
    test_specials();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
